// File: rtl/mem_line_sequencer_if.sv
// rtl/mem_line_sequencer_if.sv - request/response and line-memory bundle for mem_line_sequencer
interface mem_line_sequencer_if #(
  parameter int ADDR_WIDTH = 16
);

  // core-side request
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH:0]   req_addr_i;
  logic                  req_we_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [31:0]           req_wdata_i;

  // core-side response
  logic                  rsp_valid_o;
  logic [31:0]           rsp_rdata_o;
  logic                  rsp_err_o;

  // line-memory side
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [15:0]           mem_rd_data_i;
  logic [15:0]           mem_wr_data_o;
  logic                  mem_we_o;

  // sequencer view
  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output mem_addr_o, mem_wr_data_o, mem_we_o,
    input  mem_rd_data_i
  );

  // core + memory view
  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  mem_addr_o, mem_wr_data_o, mem_we_o,
    output mem_rd_data_i
  );

endinterface

// File: rtl/mem_line_sequencer.sv
// rtl/mem_line_sequencer.sv - byte/half/word access sequencer over a 16-bit line memory
module mem_line_sequencer #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  mem_line_sequencer_if.slave bus
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RSP  = 2'd3
  } state_e;

  state_e              state_q,    state_d;
  logic [ADDR_WIDTH:0] addr_q,     addr_d;
  logic                we_q,       we_d;
  logic [1:0]          size_q,     size_d;
  logic                uns_q,      uns_d;
  logic [31:0]         wdata_q,    wdata_d;
  logic [31:0]         data_q,     data_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,  rsp_err_d;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wr_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] line_addr;

  // Alignment rule: halves need an even byte address, words a multiple of four.
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lo);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~lo[0];
      SIZE_WORD: ok = (lo == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Sign/zero extension of a byte or half taken from one line.
  function automatic logic [31:0] extend_narrow(input logic [1:0]  size,
                                                input logic        uns,
                                                input logic        hi_byte,
                                                input logic [15:0] line);
    logic [7:0]  b;
    logic [31:0] r;
    b = hi_byte ? line[15:8] : line[7:0];
    if (size == SIZE_BYTE) begin
      r = uns ? {24'b0, b} : {{24{b[7]}}, b};
    end else begin
      r = uns ? {16'b0, line} : {{16{line[15]}}, line};
    end
    return r;
  endfunction

  assign line_addr = addr_q[ADDR_WIDTH:1];

  // Next-state, request capture, memory drive and response staging.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'b0;
    rsp_err_d   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = 16'b0;
    mem_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          we_d    = bus.req_we_i;
          size_d  = bus.req_size_i;
          uns_d   = bus.req_unsigned_i;
          wdata_d = bus.req_wdata_i;
          if (is_legal(bus.req_size_i, bus.req_addr_i[1:0])) begin
            state_d = ACC0;
          end else begin
            // Rejected requests never touch memory.
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end

      ACC0: begin
        mem_addr = line_addr;
        if (we_q) begin
          // A reset landing here must not leave a write in flight.
          mem_we = ~rst_i;
          if (size_q == SIZE_BYTE) begin
            // Memory still shows the old line this cycle, so merge in place.
            mem_wr_data = addr_q[0] ? {wdata_q[7:0], bus.mem_rd_data_i[7:0]}
                                    : {bus.mem_rd_data_i[15:8], wdata_q[7:0]};
          end else begin
            mem_wr_data = wdata_q[15:0];
          end
        end else begin
          data_d[15:0] = bus.mem_rd_data_i;
        end

        if (size_q == SIZE_WORD) begin
          state_d = ACC1;
        end else begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          if (!we_q) begin
            rsp_rdata_d = extend_narrow(size_q, uns_q, addr_q[0], data_d[15:0]);
          end
        end
      end

      ACC1: begin
        // Aligned word means line_addr is even, so +1 cannot wrap.
        mem_addr = line_addr + ADDR_WIDTH'(1);
        if (we_q) begin
          mem_we      = ~rst_i;
          mem_wr_data = wdata_q[31:16];
        end else begin
          data_d[31:16] = bus.mem_rd_data_i;
          rsp_rdata_d   = data_d;
        end
        state_d     = RSP;
        rsp_valid_d = 1'b1;
      end

      RSP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered response; reset drops any in-progress request silently.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      wdata_q     <= 32'b0;
      data_q      <= 32'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready_o   = (state_q == IDLE);
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.mem_addr_o    = mem_addr;
  assign bus.mem_wr_data_o = mem_wr_data;
  assign bus.mem_we_o      = mem_we;

endmodule

// File: tb/tb_mem_line_sequencer.sv
// tb/tb_mem_line_sequencer.sv - directed scoreboard bench for mem_line_sequencer
module tb_mem_line_sequencer;

  localparam int AW = 16;

  logic clk;
  logic rst;

  mem_line_sequencer_if #(.ADDR_WIDTH(AW)) bus ();

  mem_line_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // line memory model: async read, write at rising edge, plus a bench preload port
  logic [15:0]   mem [0:(1<<AW)-1];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [15:0]   pre_data;

  assign bus.mem_rd_data_i = mem[bus.mem_addr_o];

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wr_data_o;
  end

  int we_cnt;
  int rsp_cnt;
  always @(posedge clk) begin
    if (bus.mem_we_o) we_cnt <= we_cnt + 1;
    if (bus.rsp_valid_o) rsp_cnt <= rsp_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int total;
  int bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request at a negedge, push the expectation, then pop and compare when the
  // response arrives. Ends on the negedge after the response cycle.
  task automatic do_req(input string tag, input logic [AW:0] a, input logic we,
                        input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    exp_t e;
    int   lat;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    sb.push_back(e);
    bus.req_valid_i = 1'b1; bus.req_addr_i = a; bus.req_we_i = we;
    bus.req_size_i = sz; bus.req_unsigned_i = uns; bus.req_wdata_i = wd;
    chk({tag, "_ready"}, {31'b0, bus.req_ready_o}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    // scramble inputs after accept; the sequencer must use its registered copy
    bus.req_valid_i = 1'b0;
    bus.req_addr_i = AW'($urandom);
    bus.req_we_i = ~we;
    bus.req_size_i = 2'($urandom);
    bus.req_unsigned_i = ~uns;
    bus.req_wdata_i = $urandom;
    lat = 1;
    while (!bus.rsp_valid_o && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, {31'b0, bus.rsp_valid_o}, 32'd1);
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_rdata"}, bus.rsp_rdata_o, e.rdata);
    chk({tag, "_err"}, {31'b0, bus.rsp_err_o}, {31'b0, e.err});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, bus.rsp_valid_o}, 32'd0);
    chk({tag, "_rdclr"}, bus.rsp_rdata_o, 32'd0);
  endtask

  int w0;
  int r0;

  initial begin
    total = 0; bad = 0;
    we_cnt = 0; rsp_cnt = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_we_i = 1'b0;
    bus.req_size_i = 2'b00; bus.req_unsigned_i = 1'b0; bus.req_wdata_i = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, bus.rsp_valid_o}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
    chk("rst_err", {31'b0, bus.rsp_err_o}, 32'd0);
    chk("rst_we", {31'b0, bus.mem_we_o}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready_o}, 32'd1);

    // word store then load
    do_req("st_w", 17'h0010, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 3);
    chk("st_w_l8", {16'b0, mem[8]}, 32'h0000BEEF);
    chk("st_w_l9", {16'b0, mem[9]}, 32'h0000DEAD);
    do_req("ld_w", 17'h0010, 1'b0, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // byte read-modify-write, odd then even byte
    preload(16'd8, 16'h1234);
    do_req("st_b_odd", 17'h0011, 1'b1, 2'b00, 1'b0, 32'h555555AB, 32'h0, 1'b0, 2);
    chk("st_b_odd_l8", {16'b0, mem[8]}, 32'h0000AB34);
    do_req("st_b_even", 17'h0010, 1'b1, 2'b00, 1'b0, 32'h99999977, 32'h0, 1'b0, 2);
    chk("st_b_even_l8", {16'b0, mem[8]}, 32'h0000AB77);
    do_req("ld_bs", 17'h0011, 1'b0, 2'b00, 1'b0, 32'h0, 32'hFFFFFFAB, 1'b0, 2);
    do_req("ld_bu", 17'h0011, 1'b0, 2'b00, 1'b1, 32'h0, 32'h000000AB, 1'b0, 2);
    do_req("ld_b_even", 17'h0010, 1'b0, 2'b00, 1'b0, 32'h0, 32'h00000077, 1'b0, 2);

    // halfword loads with both extensions
    preload(16'd16, 16'h8001);
    do_req("ld_hs", 17'h0020, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0, 2);
    do_req("ld_hu", 17'h0020, 1'b0, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0, 2);

    // misaligned requests: error, no memory write
    w0 = we_cnt;
    do_req("mis_w", 17'h0002, 1'b1, 2'b10, 1'b0, 32'h11112222, 32'h0, 1'b1, 1);
    do_req("mis_h", 17'h0021, 1'b1, 2'b01, 1'b0, 32'h00003333, 32'h0, 1'b1, 1);
    chk("mis_no_we", we_cnt, w0);

    // illegal size then back-to-back legal load
    do_req("ill_sz", 17'h0020, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    do_req("b2b_h", 17'h0020, 1'b0, 2'b01, 1'b1, 32'h0, 32'h00008001, 1'b0, 2);

    // reset between halves of a word store
    preload(16'd32, 16'h0000);
    preload(16'd33, 16'h5555);
    r0 = rsp_cnt;
    bus.req_valid_i = 1'b1; bus.req_addr_i = 17'h0040; bus.req_we_i = 1'b1;
    bus.req_size_i = 2'b10; bus.req_unsigned_i = 1'b0; bus.req_wdata_i = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    chk("rm_acc0_addr", {16'b0, bus.mem_addr_o}, 32'd32);
    chk("rm_acc0_we", {31'b0, bus.mem_we_o}, 32'd1);
    @(negedge clk);
    chk("rm_acc1_addr", {16'b0, bus.mem_addr_o}, 32'd33);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rm_ready", {31'b0, bus.req_ready_o}, 32'd1);
    chk("rm_l32", {16'b0, mem[32]}, 32'h0000F00D);
    chk("rm_l33", {16'b0, mem[33]}, 32'h00005555);
    chk("rm_no_rsp", rsp_cnt, r0);

    // normal operation after the abort
    do_req("post_ld", 17'h0040, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000F00D, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_line_sequencer.md
# mem_line_sequencer

Request sequencer that sits between the core's load/store port and the 16-bit-line `Memory` array. It turns byte, halfword and word accesses at byte addresses into sequences of line accesses. Byte stores use read-modify-write; word accesses take two lines. Loads are sign- or zero-extended to 32 bits, and misaligned requests are rejected with an error response.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: memory line-address width. The byte address is `ADDR_WIDTH+1` bits.

Ports:
- `clk_i`  in  1: clock; all state changes on the rising edge.
- `rst_i`  in  1: reset; synchronous, active-high.
- `req_valid_i`  in  1: request present.
- `req_ready_o`  out  1: request accepted when `req_valid_i & req_ready_o` at a rising edge.
- `req_addr_i`  in  ADDR_WIDTH+1: byte address.
- `req_we_i`  in  1: 1 = store, 0 = load.
- `req_size_i`  in  2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned_i`  in  1: selects load extension; 1 = zero-extend, 0 = sign-extend.
- `req_wdata_i`  in  32: store data, right-aligned.
- `rsp_valid_o`  out  1: one-cycle completion pulse.
- `rsp_rdata_o`  out  32: extended load data; 0 for stores and errors.
- `rsp_err_o`  out  1: misaligned or illegal size; valid with `rsp_valid_o`.
- `mem_addr_o`  out  ADDR_WIDTH: line address to the memory.
- `mem_rd_data_i`  in  16: asynchronous read data for `mem_addr_o`, same cycle.
- `mem_wr_data_o`  out  16: line write data.
- `mem_we_o`  out  1: line write enable; the write commits at the rising edge.

## Operation
- FSM states: IDLE, ACC0, ACC1, RSP.
- **IDLE**
  - `req_ready_o`=1; all other states drive 0.
  - On accept, the request is registered.
  - If the request is legal, go to ACC0.
  - If it is illegal, go directly to RSP with the error flag set and no memory access.
- **Legality**
  - Byte: any address.
  - Half: `addr[0]`=0.
  - Word: `addr[1:0]`=0.
  - Size 11 is always illegal.
- **Line mapping**
  - Line L = `addr[ADDR_WIDTH:1]`.
  - Little-endian: even byte maps to line bits [7:0], odd byte to [15:8].
  - Word: line L holds bits [15:0], line L+1 holds [31:16].
  - L is even for an aligned word, so L+1 never wraps.
- **ACC0**
  - Drives `mem_addr_o`=L.
  - Load: captures `mem_rd_data_i` into the low half of an internal 32-bit data register.
  - Byte store: `mem_wr_data_o` = `mem_rd_data_i` with the addressed byte replaced by `wdata[7:0]`, and `mem_we_o`=1. This works because the memory returns the old contents before the write commits at the edge.
  - Half store: `mem_wr_data_o`=`wdata[15:0]`, `mem_we_o`=1.
  - Word store: writes `wdata[15:0]`.
  - Next state: ACC1 for a word, RSP otherwise.
- **ACC1** (word only)
  - Drives `mem_addr_o`=L+1.
  - Load: captures the line into the high half of the data register.
  - Store: writes `wdata[31:16]`.
  - Next state: RSP.
- **RSP**
  - `rsp_valid_o`=1 for exactly one cycle, then IDLE.
  - `rsp_rdata_o`, load case:
    - Byte: selected byte, extended from bit 7.
    - Half: line, extended from bit 15.
    - Word: assembled 32 bits.
  - `rsp_rdata_o` is 0 for stores and errors.
- **Outside ACC0/ACC1**: `mem_we_o`=0, `mem_addr_o`=0, `mem_wr_data_o`=0.
- There is no response backpressure; the consumer must take `rsp_valid_o` when it pulses.

## Timing
- **Reset**
  - State becomes IDLE.
  - `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `mem_we_o`=0.
  - `req_ready_o`=1 from the first cycle after reset deasserts.
- **Latency**, counted from the accept edge:
  - Byte/half: 1 cycle in ACC0, `rsp_valid_o` in the 2nd cycle.
  - Word: `rsp_valid_o` in the 3rd cycle.
  - Illegal: `rsp_valid_o` in the 1st cycle.
- **Throughput**: the next request can be accepted in the cycle after the RSP cycle.
  - Byte/half: 1 access per 3 cycles.
  - Word: 1 access per 4 cycles.
- **Input stability**: request inputs are ignored outside IDLE. The registered copy is used, so inputs may change freely after accept.
- **Reset mid-operation**
  - The state returns to IDLE at the reset edge.
  - A line write already committed stays committed.
  - The second half of a word store is not performed.
  - No response is issued for the aborted request.
- **Response registers**: `rsp_rdata_o` and `rsp_err_o` are registered, update on entry to RSP, and are cleared on the following edge.

## Test plan
- **Word store/load, byte 0x0010**: store 0xDEADBEEF to 0x0010, then load word from 0x0010.
  - Line 8 = 0xBEEF, line 9 = 0xDEAD.
  - Load returns 0xDEADBEEF, rsp 3 cycles after accept, err=0.
- **Byte RMW, byte 0x0011**: preload line 8 = 0x1234, store byte 0xAB to 0x0011.
  - Line 8 = 0xAB34.
  - Signed byte load of 0x0011 returns 0xFFFFFFAB.
  - Unsigned byte load of 0x0011 returns 0x000000AB.
- **Halfword load, byte 0x0020**: preload line 16 = 0x8001.
  - Signed half load from 0x0020 returns 0xFFFF8001.
  - Unsigned half load returns 0x00008001.
- **Misaligned word, byte 0x0002**: store word to 0x0002.
  - `mem_we_o` never asserts.
  - rsp in the 1st cycle after accept with err=1, rdata=0.
- **Illegal size 11**: load with size 11 → err=1.
  - Back-to-back with a legal load: `req_ready_o` held 1 in the following IDLE cycle, second request completes normally.
- **Reset between halves**: assert `rst_i` during ACC1 of a word store 0xCAFEF00D to 0x0040.
  - Line 32 = 0xF00D, line 33 unchanged.
  - No `rsp_valid_o` pulse; `req_ready_o`=1 the cycle after reset drops.
